// File: rtl/sub_ram_pkg.sv
// rtl/sub_ram_pkg.sv - shared types and helpers for the sub-RAM access sequencer
package sub_ram_pkg;

  localparam int BYTE_W    = 8;
  localparam int NUM_BANKS = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  typedef enum logic {
    ROT_LEFT  = 1'b0,
    ROT_RIGHT = 1'b1
  } rot_dir_e;

  function automatic int bank_row_w(input int addr_w);
    return addr_w - 2;
  endfunction

  function automatic logic [2:0] size_nbytes(input size_e s);
    case (s)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_rotator.sv
// rtl/byte_lane_rotator.sv - 32-bit rotate by whole bytes, direction fixed per instance
module byte_lane_rotator
  import sub_ram_pkg::*;
#(
  parameter rot_dir_e DIR = ROT_LEFT
) (
  input  logic [31:0] din,
  input  logic [1:0]  shamt,
  output logic [31:0] dout
);

  logic [5:0] sh;

  assign sh = {shamt, 3'b000};

  // A shift of 32 yields zero, so shamt=0 passes din through unchanged.
  always_comb begin
    if (DIR == ROT_LEFT) begin
      dout = (din << sh) | (din >> (6'd32 - sh));
    end else begin
      dout = (din >> sh) | (din << (6'd32 - sh));
    end
  end

endmodule

// File: rtl/sub_ram_access_sequencer.sv
// rtl/sub_ram_access_sequencer.sv - byte/half/word sequencer over four 8-bit sub-RAM banks
// Optional macro SUB_RAM_ALIGN_CHECK_EN rejects misaligned half/word requests.
module sub_ram_access_sequencer #(
  parameter int ADDR_W      = 18,
  parameter int NUM_BANKS   = 4,
  parameter int RAM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic                          req_we,
  input  logic [1:0]                    req_size,
  input  logic [31:0]                   req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_rdata,
  output logic                          rsp_err,
  output logic [NUM_BANKS-1:0]          bank_en,
  output logic [NUM_BANKS-1:0]          bank_we,
  output logic [NUM_BANKS*(ADDR_W-2)-1:0] bank_row,
  output logic [31:0]                   bank_wdata,
  input  logic [31:0]                   bank_rdata
);
  import sub_ram_pkg::*;

  localparam int RW = bank_row_w(ADDR_W);

  seq_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  size_e       size_q, size_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  size_e       size;
  logic [1:0]  off;
  logic [RW-1:0] row;
  logic [2:0]  nbytes;
  logic        accept, req_err, access;
  logic [1:0]  rel;
  logic [31:0] wdata_rot, rd_rot, rd_masked;

  assign size   = size_e'(req_size);
  assign off    = req_addr[1:0];
  assign row    = req_addr[ADDR_W-1:2];
  assign nbytes = size_nbytes(size);
  assign accept = req_valid && req_ready_q;
  assign access = accept && !req_err;

  always_comb begin
    req_err = (size == SZ_RSVD);
`ifdef SUB_RAM_ALIGN_CHECK_EN
    if ((size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'd0)) begin
      req_err = 1'b1;
    end
`endif
  end

  byte_lane_rotator #(.DIR(ROT_LEFT)) u_wr_rot (
    .din   (req_wdata),
    .shamt (off),
    .dout  (wdata_rot)
  );

  byte_lane_rotator #(.DIR(ROT_RIGHT)) u_rd_rot (
    .din   (bank_rdata),
    .shamt (off_q),
    .dout  (rd_rot)
  );

  // Banks below the start offset hold the tail bytes, which live one row further on.
  always_comb begin
    bank_en    = '0;
    bank_we    = '0;
    bank_row   = '0;
    bank_wdata = '0;
    rel        = '0;
    if (access) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        rel        = 2'(i) - off;
        bank_en[i] = ({1'b0, rel} < nbytes);
        bank_row[i*RW +: RW] = (2'(i) < off) ? row + RW'(1) : row;
      end
      bank_we    = req_we ? bank_en : '0;
      bank_wdata = wdata_rot;
    end
  end

  always_comb begin
    rd_masked = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < size_nbytes(size_q)) begin
        rd_masked[k*BYTE_W +: BYTE_W] = rd_rot[k*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    size_d      = size_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          off_d       = off;
          size_d      = size;
          req_ready_d = 1'b0;
          if (req_err || req_we) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
            rsp_rdata_d = '0;
          end else begin
            state_d = WAIT;
            cnt_d   = 2'(RAM_LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = rd_masked;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      size_q      <= SZ_BYTE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      size_q      <= size_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sub_ram_access_sequencer.sv
// tb/tb_sub_ram_access_sequencer.sv - directed and randomized checks against a byte-addressed memory model
module tb_sub_ram_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid3, req_we, rsp_ready, rsp_ready3;
  logic [17:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, bank_wdata, bank_rdata;
  logic [3:0]  bank_en, bank_we;
  logic [63:0] bank_row;

  logic        req_ready3, rsp_valid3, rsp_err3;
  logic [31:0] rsp_rdata3, bank_wdata3, bank_rdata3;
  logic [3:0]  bank_en3, bank_we3;
  logic [63:0] bank_row3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sub_ram_access_sequencer #(.ADDR_W(18), .NUM_BANKS(4), .RAM_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .bank_en(bank_en),
    .bank_we(bank_we), .bank_row(bank_row), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  sub_ram_access_sequencer #(.ADDR_W(18), .NUM_BANKS(4), .RAM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .bank_en(bank_en3),
    .bank_we(bank_we3), .bank_row(bank_row3), .bank_wdata(bank_wdata3), .bank_rdata(bank_rdata3)
  );

  function automatic logic [7:0] init_val(input int a);
    logic [31:0] x;
    x = 32'(a) * 32'h9E3779B1;
    return x[31:24];
  endfunction

  // Physical bank storage: four 8-bit banks, 2^16 rows each, driven by the DUT bank strobes.
  logic [7:0]  bmem [0:262143];
  bit          bwr  [0:262143];
  logic [63:0] garbage;
  logic [31:0] rd1_next, rd3_next, pipe1;
  logic [95:0] pipe3;

  always_comb begin
    rd1_next = '0;
    rd3_next = '0;
    for (int i = 0; i < 4; i++) begin
      rd1_next[i*8 +: 8] = !bank_en[i] ? garbage[i*8 +: 8] :
        (bwr[i*65536 + int'(bank_row[i*16 +: 16])] ? bmem[i*65536 + int'(bank_row[i*16 +: 16])]
                                                    : init_val(int'(bank_row[i*16 +: 16])*4 + i));
      rd3_next[i*8 +: 8] = !bank_en3[i] ? garbage[32 + i*8 +: 8] :
        (bwr[i*65536 + int'(bank_row3[i*16 +: 16])] ? bmem[i*65536 + int'(bank_row3[i*16 +: 16])]
                                                     : init_val(int'(bank_row3[i*16 +: 16])*4 + i));
    end
  end

  always @(posedge clk) begin
    garbage <= {$urandom, $urandom};
    pipe1   <= rd1_next;
    pipe3   <= {pipe3[63:0], rd3_next};
    for (int i = 0; i < 4; i++) begin
      if (bank_we[i]) begin
        bmem[i*65536 + int'(bank_row[i*16 +: 16])] <= bank_wdata[i*8 +: 8];
        bwr[i*65536 + int'(bank_row[i*16 +: 16])]  <= 1'b1;
      end
    end
  end

  assign bank_rdata  = pipe1;
  assign bank_rdata3 = pipe3[95:64];

  // Reference model: flat byte-addressed memory, 2^18 bytes, wrapping at the top.
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] ref_get(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_bank_en"}, 64'(bank_en), 64'd0);
    check({tag, "_bank_we"}, 64'(bank_we), 64'd0);
    check({tag, "_bank_row"}, bank_row, 64'd0);
    check({tag, "_bank_wdata"}, 64'(bank_wdata), 64'd0);
    check({tag, "_rsp_valid3"}, 64'(rsp_valid3), 64'd0);
  endtask

  task automatic do_op(input bit u3, input logic [17:0] a, input logic we, input logic [1:0] sz,
                       input logic [31:0] wd, input int hold, output logic [31:0] got);
    int n, lat;
    bit err;
    logic [3:0]  een;
    logic [63:0] erow;
    logic [31:0] ewd, erd, exp_rsp;
    logic [17:0] ba;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    err = (sz == 2'd3);
`ifdef SUB_RAM_ALIGN_CHECK_EN
    if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) err = 1'b1;
`endif
    een = '0; ewd = '0; erd = '0; erow = '0;
    for (int j = 0; j < 4; j++) begin
      ba = a + 18'(j);
      ewd[int'(ba[1:0])*8 +: 8] = wd[j*8 +: 8];
      if (j < n && !err) begin
        een[ba[1:0]]  = 1'b1;
        erd[j*8 +: 8] = ref_get(int'(ba));
      end
    end
    for (int i = 0; i < 4; i++) begin
      ba = a + 18'((i - int'(a[1:0])) & 3);
      erow[i*16 +: 16] = ba[17:2];
    end
    exp_rsp = (we || err) ? 32'd0 : erd;

    @(negedge clk);
    req_addr = a; req_we = we; req_size = sz; req_wdata = wd;
    if (u3) req_valid3 = 1'b1; else req_valid = 1'b1;
    #1;
    check("accept_ready", 64'(u3 ? req_ready3 : req_ready), 64'd1);
    check("bank_en", 64'(u3 ? bank_en3 : bank_en), 64'(een));
    check("bank_we", 64'(u3 ? bank_we3 : bank_we), 64'(we ? een : 4'd0));
    if (!err) check("bank_row", u3 ? bank_row3 : bank_row, erow);
    if (we && !err) check("bank_wdata", 64'(u3 ? bank_wdata3 : bank_wdata), 64'(ewd));
    @(posedge clk);
    if (we && !err) begin
      for (int j = 0; j < n; j++) begin
        ba = a + 18'(j);
        ref_mem[int'(ba)] = wd[j*8 +: 8];
      end
    end
    @(negedge clk);
    req_valid = 1'b0; req_valid3 = 1'b0;
    lat = (we || err) ? 1 : (u3 ? 4 : 2);
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      check("bank_en_idle", 64'(u3 ? bank_en3 : bank_en), 64'd0);
      if (k < lat) begin
        check("rsp_early", 64'(u3 ? rsp_valid3 : rsp_valid), 64'd0);
        check("req_ready_wait", 64'(u3 ? req_ready3 : req_ready), 64'd0);
      end
    end
    check("rsp_valid", 64'(u3 ? rsp_valid3 : rsp_valid), 64'd1);
    check("rsp_err", 64'(u3 ? rsp_err3 : rsp_err), 64'(err));
    check("rsp_rdata", 64'(u3 ? rsp_rdata3 : rsp_rdata), 64'(exp_rsp));
    got = u3 ? rsp_rdata3 : rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      check("hold_valid", 64'(u3 ? rsp_valid3 : rsp_valid), 64'd1);
      check("hold_rdata", 64'(u3 ? rsp_rdata3 : rsp_rdata), 64'(exp_rsp));
      check("hold_err", 64'(u3 ? rsp_err3 : rsp_err), 64'(err));
      check("hold_ready", 64'(u3 ? req_ready3 : req_ready), 64'd0);
    end
    if (u3) rsp_ready3 = 1'b1; else rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0; rsp_ready3 = 1'b0;
    #1;
    check("rsp_dropped", 64'(u3 ? rsp_valid3 : rsp_valid), 64'd0);
    check("back_idle", 64'(u3 ? req_ready3 : req_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] got;
    logic [17:0] ra;
    logic [1:0]  rs;
    logic        rwe;
    bit          ru3;

    rst = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
    rsp_ready3 = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    reset_check("reset");
    @(negedge clk);
    rst = 1'b0;

    do_op(1'b0, 18'h00008, 1'b1, 2'd2, 32'hAABBCCDD, 0, got);
    do_op(1'b0, 18'h00007, 1'b1, 2'd1, 32'h00001234, 2, got);
    do_op(1'b0, 18'h00006, 1'b1, 2'd1, 32'h00005678, 0, got);
    do_op(1'b0, 18'h00006, 1'b0, 2'd1, 32'h0, 0, got);
    check("tp3_lat1", 64'(got), 64'h5678);
    do_op(1'b1, 18'h00006, 1'b0, 2'd1, 32'h0, 0, got);
    check("tp3_lat3", 64'(got), 64'h5678);
    do_op(1'b0, 18'h3FFFD, 1'b1, 2'd2, 32'h11223344, 0, got);
    do_op(1'b0, 18'h3FFFD, 1'b0, 2'd2, 32'h0, 0, got);
`ifndef SUB_RAM_ALIGN_CHECK_EN
    check("tp4_wrap", 64'(got), 64'h11223344);
`endif
    do_op(1'b0, 18'h00105, 1'b0, 2'd0, 32'h0, 5, got);
    do_op(1'b0, 18'h00020, 1'b1, 2'd3, 32'hFFFFFFFF, 1, got);
    do_op(1'b1, 18'h00021, 1'b0, 2'd3, 32'h0, 0, got);
    do_op(1'b0, 18'h00001, 1'b0, 2'd2, 32'h0, 0, got);
    do_op(1'b0, 18'h00003, 1'b1, 2'd1, 32'hCAFE0000, 0, got);

    for (int it = 0; it < 60; it++) begin
      ru3 = ($urandom_range(0, 3) == 0);
      ra  = 18'($urandom);
      if ($urandom_range(0, 4) == 0) ra = 18'h3FFFC + 18'($urandom_range(0, 3));
      else if ($urandom_range(0, 2) == 0) ra = 18'h00040 + 18'($urandom_range(0, 15));
      rwe = ru3 ? 1'b0 : 1'($urandom);
      rs  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_op(ru3, ra, rwe, rs, $urandom, $urandom_range(0, 3), got);
    end

    // Abort while the read is still waiting on bank data.
    @(negedge clk);
    req_addr = 18'h00104; req_we = 1'b0; req_size = 2'd2; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    #1;
    reset_check("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("rst_wait_no_rsp", 64'(rsp_valid), 64'd0);
      check("rst_wait_ready", 64'(req_ready), 64'd1);
    end

    // Abort while a response is being held under backpressure.
    do_op(1'b0, 18'h00100, 1'b1, 2'd2, 32'hDEADBEEF, 0, got);
    @(negedge clk);
    req_addr = 18'h00100; req_we = 1'b0; req_size = 2'd2; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk); #1;
    check("pre_rst_valid", 64'(rsp_valid), 64'd1);
    check("pre_rst_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    rst = 1'b1;
    #1;
    reset_check("rst_resp");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      check("rst_resp_no_rsp", 64'(rsp_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_ram_access_sequencer.md
Name: sub_ram_access_sequencer

Overview:
Front-end controller for the composed 32-bit-word / 18-bit-byte-address RAM, built from four 8-bit sub-RAM banks.
- Accepts byte, half and word requests at any byte offset. Bank index = byte-address modulo 4.
- Computes per-bank row addresses and lane enables, and rotates write data into bank lanes.
- Waits out the sub-RAM read latency, then rotates read data back and holds the response under a valid/ready handshake.

Parameters:
ADDR_W, 18, byte address width; bank row width is ADDR_W-2.
NUM_BANKS, 4, number of 8-bit sub-RAM banks (fixed at 4).
RAM_LATENCY, 1, cycles from bank_en to valid bank_rdata (1..3).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept
req_addr  in  ADDR_W  byte address
req_we  in  1  1=write, 0=read
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_wdata  in  32  write data, little-endian, byte 0 in [7:0]
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  read data, zero-extended; 0 for writes
rsp_err  out  1  request rejected, no bank access made
bank_en  out  4  per-bank access strobe
bank_we  out  4  per-bank write strobe
bank_row  out  4*(ADDR_W-2)  row per bank, bank i in slice i
bank_wdata  out  32  lane i = bank i data
bank_rdata  in  32  lane i = bank i read data

Behaviour:
- Reset, asynchronous: state=IDLE. req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, bank_en=0, bank_we=0, bank_row=0, bank_wdata=0.
- States:
  - IDLE: req_ready=1.
  - WAIT: down-counter loaded with RAM_LATENCY-1.
  - RESP: rsp_valid=1.
- Accept: a request is accepted at cycle T when req_valid && req_ready. Bank outputs are driven combinationally in T only; bank_en/bank_we are 0 in every other cycle.
- Address mapping: off=req_addr[1:0], row=req_addr[ADDR_W-1:2], nbytes=1/2/4 by size.
  - Bank i row = row + 1 if i < off, else row.
  - Row overflow on the +1 wraps modulo 2^(ADDR_W-2).
- Lane mapping: byte j (j<nbytes) maps to bank (off+j) mod 4.
  - bank_en[(off+j)%4]=1 for each valid byte j.
  - Write: bank_we mirrors bank_en; bank_wdata = req_wdata rotated left by off bytes.
- Write accepted: IDLE->RESP. rsp_valid=1 from T+1, rsp_rdata=0.
- Read accepted: IDLE->WAIT.
  - bank_rdata is sampled at the edge ending cycle T+RAM_LATENCY.
  - Sampled data is rotated right by off bytes, bytes >= nbytes are zeroed, and the result is registered.
  - WAIT->RESP; rsp_valid=1 from T+RAM_LATENCY+1.
  - off and size are latched at accept.
- RESP: rsp_rdata/rsp_err are held stable until rsp_valid && rsp_ready. Then ->IDLE and rsp_valid drops the next cycle. One request is in flight at most; no back-to-back accept in the RESP cycle.
- req_size=11: no bank_en. IDLE->RESP, rsp_err=1, rsp_rdata=0 at T+1.
- rsp_ready held high: the response is consumed in its first valid cycle, so request throughput is one per RAM_LATENCY+2 cycles for reads.
- rst mid-operation: abort immediately, return to reset values. No response is issued for the in-flight request; the bank write already strobed at T stands.

Optional Feature:
SUB_RAM_ALIGN_CHECK_EN
- Defined: a half request with off[0]=1, or a word request with off!=0, is rejected exactly like size 11 (rsp_err=1, no bank_en, response at T+1).
- Undefined: all offsets are performed via rotation as above, and rsp_err asserts only for size 11.

Decomposition:
- Package sub_ram_pkg:
  - size_e enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD)
  - seq_state_e (IDLE, WAIT, RESP)
  - BYTE_W=8, NUM_BANKS=4, BANK_ROW_W function of ADDR_W
- Sub-module byte_lane_rotator: 32-bit, 2-bit byte shamt, direction parameter (LEFT/RIGHT). Instantiated twice: write path LEFT, read path RIGHT.

Test Plan:
1. Word write, addr=0x00008, wdata=0xAABBCCDD -> at T: bank_en=1111, bank_we=1111, all rows 0x0002, bank_wdata=0xAABBCCDD. rsp_valid at T+1, rsp_err=0.
2. Half write, addr=0x00007, wdata=0x00001234 -> bank_en=1001, bank3 row 0x0001 data 0x34, bank0 row 0x0002 data 0x12.
3. Read, addr=0x00006, size=half, bank model returns rows such that bank2=0x78, bank3=0x56 -> rsp_rdata=0x00005678 at T+2 (RAM_LATENCY=1). Repeat with RAM_LATENCY=3 -> response at T+4.
4. Word read, addr=0x3FFFD (top row) -> bank0..0 rows wrap: bank0 row 0x0000, banks 1-3 row 0xFFFF. Rotated data checked.
5. Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout. Release -> IDLE next cycle.
6. size=11 -> bank_en=0, rsp_err=1 at T+1. Assert rst during WAIT -> all outputs at reset values immediately, no rsp_valid.
   - With SUB_RAM_ALIGN_CHECK_EN defined: word at addr=0x00001 -> rsp_err=1, no bank_en.
